// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM receiver.
// Optional frame check is enabled with I2S_RX_FRAME_CHECK_EN.
package i2s_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SKIP,
        RUN,
        WAIT
    } rx_state_e;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    // ceil(log2(v)), never below 1 so the result can size a port
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser; EDGE_D also gets a rise detector.
// Level-only inputs ride along in D/Q with the same latency.
module i2s_sync_edge #(
    parameter int W = 2
) (
    input  logic         MCLK,
    input  logic         RST_N,
    input  logic         EDGE_D,
    input  logic [W-1:0] D,
    output logic         RISE,
    output logic [W-1:0] Q
);

    logic [W:0] s1;
    logic [W:0] s2;
    logic       prev;

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            s1   <= '0;
            s2   <= '0;
            prev <= 1'b0;
        end else begin
            s1   <= {D, EDGE_D};
            s2   <= s1;
            prev <= s2[0];
        end
    end

    assign Q    = s2[W:1];
    assign RISE = s2[0] & ~prev;

endmodule

// File: rtl/i2s_rx_tdm.sv
// I2S / left-justified / TDM receiver on MCLK, one word per slot.
// Define I2S_RX_FRAME_CHECK_EN to enable the FRAME_ERR frame-length check.
module i2s_rx_tdm
    import i2s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SLOT_W = 32,
    parameter int NCH    = 2,
    parameter int CH_W   = clog2(NCH)
) (
    input  logic              MCLK,
    input  logic              RST_N,
    input  logic              BCLK,
    input  logic              LRCLK,
    input  logic              SDATA,
    input  logic              MODE,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CH_W-1:0]   OUT_CH,
    output logic              OUT_VALID,
    output logic              FRAME_ERR
);

    localparam int BW = clog2(SLOT_W + 1);
    localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0]   SLOT_LAST = BW'(SLOT_W - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NCH - 1);

    logic bclk_rise, lr_s, sd_s, fs;

    i2s_sync_edge #(.W(2)) u_sync (
        .MCLK   (MCLK),
        .RST_N  (RST_N),
        .EDGE_D (BCLK),
        .D      ({LRCLK, SDATA}),
        .RISE   (bclk_rise),
        .Q      ({lr_s, sd_s})
    );

    rx_state_e         state, state_n;
    logic [BW-1:0]     bit_cnt, bit_n, cur_bit;
    logic [CH_W-1:0]   ch_cnt, ch_n, cur_ch;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              lr_prev, lr_prev_n;
    logic              pend, pend_n;
    logic [CH_W-1:0]   pend_ch, pend_ch_n;
    logic              take;

    assign fs = bclk_rise & lr_prev & ~lr_s;

    always_comb begin
        state_n   = state;
        bit_n     = bit_cnt;
        ch_n      = ch_cnt;
        shreg_n   = shreg;
        lr_prev_n = lr_prev;
        pend_n    = 1'b0;
        pend_ch_n = pend_ch;
        cur_bit   = bit_cnt;
        cur_ch    = ch_cnt;
        take      = 1'b0;
        if (fs) begin
            // restart at slot 0; in LJ mode this rise already carries the MSB
            lr_prev_n = lr_s;
            state_n   = SKIP;
            bit_n     = '0;
            ch_n      = '0;
            cur_bit   = '0;
            cur_ch    = '0;
            take      = (MODE == MODE_LJ);
        end else if (bclk_rise) begin
            lr_prev_n = lr_s;
            take      = (state == SKIP) || (state == RUN);
        end
        if (take) begin
            if (cur_bit <= DATA_LAST)
                shreg_n = DATA_W'({shreg, sd_s});
            if (cur_bit == DATA_LAST) begin
                pend_n    = 1'b1;
                pend_ch_n = cur_ch;
            end
            state_n = RUN;
            bit_n   = cur_bit + 1'b1;
            if (cur_bit == SLOT_LAST) begin
                bit_n = '0;
                ch_n  = cur_ch + 1'b1;
                if (cur_ch == CH_LAST) begin
                    ch_n    = '0;
                    state_n = WAIT;
                end
            end
        end
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            ch_cnt    <= '0;
            shreg     <= '0;
            lr_prev   <= 1'b0;
            pend      <= 1'b0;
            pend_ch   <= '0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_n;
            ch_cnt    <= ch_n;
            shreg     <= shreg_n;
            lr_prev   <= lr_prev_n;
            pend      <= pend_n;
            pend_ch   <= pend_ch_n;
            OUT_VALID <= pend;
            if (pend) begin
                OUT_DATA <= shreg;
                OUT_CH   <= pend_ch;
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int FW = clog2(NCH * SLOT_W + 2);
    localparam logic [FW-1:0] F_LEN = FW'(NCH * SLOT_W);
    localparam logic [FW-1:0] F_SAT = FW'(NCH * SLOT_W + 1);

    logic [FW-1:0] fcnt, fcnt_inc;

    assign fcnt_inc = (fcnt == F_SAT) ? fcnt : fcnt + 1'b1;

    // count includes the closing fs rise; HUNT means no frame to measure yet
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            fcnt      <= '0;
            FRAME_ERR <= 1'b0;
        end else begin
            FRAME_ERR <= fs && (state != HUNT) && (fcnt_inc != F_LEN);
            if (fs)
                fcnt <= '0;
            else if (bclk_rise)
                fcnt <= fcnt_inc;
        end
    end
`else
    assign FRAME_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Bench for i2s_rx_tdm: stereo (16/32/2) and TDM (24/32/4) instances
// fed from one serial stream built by a frame-level model.
module tb_i2s_rx_tdm;

    logic MCLK = 1'b0;
    logic RST_N, BCLK, LRCLK, SDATA, MODE;

    logic [15:0] st_data;
    logic [0:0]  st_ch;
    logic        st_vld, st_err;
    logic [23:0] td_data;
    logic [1:0]  td_ch;
    logic        td_vld, td_err;

    always #5 MCLK = ~MCLK;

    i2s_rx_tdm u_st (
        .MCLK      (MCLK),
        .RST_N     (RST_N),
        .BCLK      (BCLK),
        .LRCLK     (LRCLK),
        .SDATA     (SDATA),
        .MODE      (MODE),
        .OUT_DATA  (st_data),
        .OUT_CH    (st_ch),
        .OUT_VALID (st_vld),
        .FRAME_ERR (st_err)
    );

    i2s_rx_tdm #(.DATA_W(24), .SLOT_W(32), .NCH(4)) u_td (
        .MCLK      (MCLK),
        .RST_N     (RST_N),
        .BCLK      (BCLK),
        .LRCLK     (LRCLK),
        .SDATA     (SDATA),
        .MODE      (MODE),
        .OUT_DATA  (td_data),
        .OUT_CH    (td_ch),
        .OUT_VALID (td_vld),
        .FRAME_ERR (td_err)
    );

    typedef struct {
        int          ch;
        logic [23:0] d;
    } out_t;

    typedef struct {
        logic lr;
        logic sd;
        int   idle;
        bit   rst;
    } bit_t;

    typedef struct {
        bit               tdm;
        bit               mode;
        bit               lj;
        bit               rnd;
        logic [3:0][23:0] w;
        logic [3:0][23:0] e;
    } vec_t;

    out_t got0[$];
    out_t got1[$];
    out_t exp_q[$];
    bit_t bq[$];
    vec_t vt[5];

    int   checks = 0;
    int   errors = 0;
    int   ferr0 = 0, ferr1 = 0, dbl = 0;
    logic pv0 = 1'b0, pv1 = 1'b0;
    out_t o0, o1;

    int   cnt[2];
    int   exp_err[2];
    bit   armed[2];
    logic prev_lr;
    logic carry;
    int   flen_of[2] = '{64, 128};

    always @(negedge MCLK) begin
        if (st_vld) begin
            o0.ch = int'(st_ch);
            o0.d  = 24'(st_data);
            got0.push_back(o0);
        end
        if (td_vld) begin
            o1.ch = int'(td_ch);
            o1.d  = td_data;
            got1.push_back(o1);
        end
        if (st_err) ferr0++;
        if (td_err) ferr1++;
        if ((st_vld && pv0) || (td_vld && pv1)) dbl++;
        pv0 = st_vld;
        pv1 = td_vld;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cnt[d]   = 0;
            armed[d] = 1'b0;
        end
        prev_lr = 1'b0;
    endtask

    // frame length = BCLK rises from one LRCLK fall to the next
    task automatic model_rise(input logic lr);
        for (int d = 0; d < 2; d++) begin
            if (cnt[d] < 100000) cnt[d]++;
            if (prev_lr && !lr) begin
`ifdef I2S_RX_FRAME_CHECK_EN
                if (armed[d] && cnt[d] != flen_of[d]) exp_err[d]++;
`endif
                armed[d] = 1'b1;
                cnt[d]   = 0;
            end
        end
        prev_lr = lr;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_st_vld"},  st_vld,  0);
        chk({tag, "_st_data"}, st_data, 0);
        chk({tag, "_st_ch"},   st_ch,   0);
        chk({tag, "_st_err"},  st_err,  0);
        chk({tag, "_td_vld"},  td_vld,  0);
        chk({tag, "_td_data"}, td_data, 0);
        chk({tag, "_td_ch"},   td_ch,   0);
        chk({tag, "_td_err"},  td_err,  0);
    endtask

    task automatic play();
        bit_t b;
        while (bq.size() > 0) begin
            b = bq.pop_front();
            repeat (b.idle) @(negedge MCLK);
            BCLK  = 1'b0;
            LRCLK = b.lr;
            SDATA = b.sd;
            if (b.rst) begin
                RST_N = 1'b0;
                #1;
                reset_checks("rst_mid");
                repeat (3) @(negedge MCLK);
                RST_N = 1'b1;
                model_reset();
            end
            repeat (4) @(negedge MCLK);
            BCLK = 1'b1;
            model_rise(b.lr);
            repeat (4) @(negedge MCLK);
        end
    endtask

    task automatic add_bits(input logic lr, input int n, input int idle);
        bit_t b;
        for (int k = 0; k < n; k++) begin
            b.lr   = lr;
            b.sd   = 1'($urandom_range(0, 1));
            b.idle = (k == 0) ? idle : 0;
            b.rst  = 1'b0;
            bq.push_back(b);
        end
    endtask

    // lj: MSB on the LRCLK-fall bit, else one bit later; len < full = early fs
    task automatic add_frame(input bit tdm, input bit lj,
                             input logic [3:0][23:0] w,
                             input logic [3:0][23:0] ew,
                             input int len, input bit rnd, input int rst_at);
        int          nch, dw, flen, pos;
        logic        dbit[128];
        logic [23:0] mask;
        bit_t        b;
        out_t        o;
        nch  = tdm ? 4 : 2;
        dw   = tdm ? 24 : 16;
        flen = nch * 32;
        mask = tdm ? 24'hFFFFFF : 24'h00FFFF;
        for (int j = 0; j < flen; j++) begin
            if (j % 32 < dw)
                dbit[j] = w[j / 32][dw - 1 - (j % 32)];
            else
                dbit[j] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        for (int j = 0; j < len; j++) begin
            b.lr   = (j >= flen / 2);
            b.sd   = lj ? dbit[j] : ((j == 0) ? carry : dbit[j - 1]);
            b.idle = 0;
            b.rst  = (j == rst_at);
            bq.push_back(b);
        end
        carry = dbit[len - 1];
        for (int s = 0; s < nch; s++) begin
            pos = (lj ? 0 : 1) + s * 32 + dw - 1;
            if (pos < len && (rst_at < 0 || pos < rst_at)) begin
                o.ch = s;
                o.d  = ew[s] & mask;
                exp_q.push_back(o);
            end
        end
    endtask

    task automatic run(input int tgt, input string nm);
        int   base;
        out_t g[$];
        base = tgt ? got1.size() : got0.size();
        play();
        repeat (4) @(negedge MCLK);
        g = tgt ? got1 : got0;
        chk({nm, "_count"}, g.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size() && base + k < g.size(); k++) begin
            chk($sformatf("%s_data%0d", nm, k), g[base + k].d, exp_q[k].d);
            chk($sformatf("%s_ch%0d", nm, k), g[base + k].ch, exp_q[k].ch);
        end
        chk({nm, "_ferr_st"}, ferr0, exp_err[0]);
        chk({nm, "_ferr_td"}, ferr1, exp_err[1]);
        exp_q.delete();
    endtask

    task automatic set_vec(input int i, input bit tdm, input bit mode,
                           input bit lj, input bit rnd,
                           input logic [95:0] w, input logic [95:0] e);
        vt[i].tdm  = tdm;
        vt[i].mode = mode;
        vt[i].lj   = lj;
        vt[i].rnd  = rnd;
        vt[i].w    = w;
        vt[i].e    = e;
    endtask

    initial begin
        logic [3:0][23:0] w;
        logic [3:0][23:0] w2;
        bit               tg, m;

        set_vec(0, 0, 0, 0, 1, {48'h0, 24'h001234, 24'h00A5C3},
                               {48'h0, 24'h001234, 24'h00A5C3});
        set_vec(1, 0, 1, 1, 1, {48'h0, 24'h001234, 24'h00A5C3},
                               {48'h0, 24'h001234, 24'h00A5C3});
        set_vec(2, 0, 0, 1, 0, {48'h0, 24'h001234, 24'h00A5C3},
                               {48'h0, 24'h002468, 24'h004B86});
        set_vec(3, 1, 0, 0, 1,
                {24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800001},
                {24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800001});
        set_vec(4, 1, 1, 1, 1,
                {24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800001},
                {24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800001});

        exp_err[0] = 0;
        exp_err[1] = 0;
        carry      = 1'b0;
        model_reset();
        RST_N = 1'b0;
        BCLK  = 1'b0;
        LRCLK = 1'b1;
        SDATA = 1'b0;
        MODE  = 1'b0;
        repeat (3) @(negedge MCLK);
        reset_checks("rst_init");
        RST_N = 1'b1;
        repeat (2) @(negedge MCLK);

        for (int v = 0; v < 5; v++) begin
            MODE = vt[v].mode;
            add_bits(1'b1, 3, 0);
            for (int f = 0; f < 2; f++)
                add_frame(vt[v].tdm, vt[v].lj, vt[v].w, vt[v].e,
                          vt[v].tdm ? 128 : 64, vt[v].rnd, -1);
            add_bits(1'b1, 3, 0);
            run(vt[v].tdm ? 1 : 0, $sformatf("vec%0d", v));
        end

        for (int it = 0; it < 6; it++) begin
            tg   = 1'($urandom_range(0, 1));
            m    = 1'($urandom_range(0, 1));
            MODE = m;
            add_bits(1'b1, $urandom_range(2, 5), 0);
            for (int f = 0; f < 2; f++) begin
                for (int s = 0; s < 4; s++) w[s] = 24'($urandom);
                add_frame(tg, m, w, w, tg ? 128 : 64, 1'b1, -1);
            end
            add_bits(1'b1, 3, 0);
            run(tg ? 1 : 0, $sformatf("rnd%0d", it));
        end

        // early fs: after 20 right-slot bits the word is complete, after 10 not
        MODE = 1'b0;
        w  = {48'h0, 24'h00BEEF, 24'h00CAFE};
        w2 = {48'h0, 24'h000F0F, 24'h007001};
        add_bits(1'b1, 3, 0);
        add_frame(0, 0, w, w, 64, 1'b1, -1);
        add_frame(0, 0, w2, w2, 1 + 32 + 20, 1'b1, -1);
        add_frame(0, 0, w, w, 64, 1'b1, -1);
        add_frame(0, 0, w2, w2, 1 + 32 + 10, 1'b1, -1);
        add_frame(0, 0, w, w, 64, 1'b1, -1);
        add_bits(1'b1, 3, 0);
        run(0, "early_fs");

        MODE = 1'b1;
        add_bits(1'b1, 3, 0);
        add_frame(0, 1, w, w, 64, 1'b1, -1);
        add_frame(0, 1, w2, w2, 64, 1'b1, 10);
        add_frame(0, 1, w2, w2, 64, 1'b1, -1);
        add_bits(1'b1, 3, 0);
        run(0, "mid_reset");

        add_bits(1'b1, 3, 0);
        add_frame(0, 1, w, w, 64, 1'b1, -1);
        add_bits(1'b1, 4, 60);
        add_bits(1'b1, 4, 0);
        add_frame(0, 1, w2, w2, 64, 1'b1, -1);
        add_bits(1'b1, 3, 0);
        run(0, "idle_bclk");

        chk("valid_back_to_back", dbl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
